uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter DATA_W, default 8, frame payload width.
REQ-003 Parameter TIMEOUT, default 1024, cycles allowed between TxStart and TxBusy rising.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 Req  input  N_REQ  per-requester transmit request, level-sensitive.
REQ-007 DataIN  input  N_REQ*DATA_W  packed payloads; slice i = DataIN[i*DATA_W +: DATA_W].
REQ-008 Grant  output  N_REQ  one-hot owner of the transmitter; all-zero when idle.
REQ-009 Ack  output  N_REQ  one-cycle pulse to the owner when its frame completes.
REQ-010 TxStart  output  1  one-cycle start strobe to the UART transmitter.
REQ-011 TxData  output  DATA_W  payload presented to the transmitter, held stable while Grant is non-zero.
REQ-012 TxBusy  input  1  transmitter is shifting a frame.
REQ-013 TxDone  input  1  one-cycle pulse from the transmitter at end of stop bit.
REQ-014 ErrTimeout  output  1  sticky flag: transmitter never went busy after TxStart.

Function
REQ-015 The FSM SHALL have states IDLE, START, WAIT_BUSY, WAIT_DONE; all outputs are registered or decoded from registered state only.
REQ-016 IDLE: on an edge where Req != 0, select winner by round-robin starting at index (Last+1) mod N_REQ, set Grant to one-hot winner, latch TxData from the winner's slice, and go to START.
REQ-017 Last SHALL update to the winner index only when that winner's Ack pulses or its transfer times out.
REQ-018 START: TxStart SHALL be 1 for exactly this one cycle; the next state is WAIT_BUSY with timeout counter cleared to 0.
REQ-019 WAIT_BUSY: TxBusy=1 -> WAIT_DONE; TxDone=1 (even if busy was never seen) -> treat as completion per REQ-020; otherwise counter increments, and when it reaches TIMEOUT-1 -> set ErrTimeout, clear Grant with no Ack, return to IDLE.
REQ-020 WAIT_DONE: on TxDone=1, pulse Ack[winner] for one cycle, clear Grant to 0 on the same edge, return to IDLE.
REQ-021 Latency: Req sampled at edge k -> Grant/TxData valid after edge k, TxStart high between edges k and k+1; Ack high in the cycle following the edge that sampled TxDone.
REQ-022 Minimum gap between consecutive grants is one IDLE cycle; back-to-back requests from the same requester SHALL be re-served only after all other pending requesters have been served once.
REQ-023 Req or DataIN changes after grant SHALL NOT affect TxData, Grant, or completion; a dropped Req still receives its Ack.
REQ-024 Only one Ack bit and at most one Grant bit SHALL ever be high; Ack and TxStart are never high together.
REQ-025 TxDone while in IDLE or START SHALL be ignored.
REQ-026 Counter width SHALL be clog2(TIMEOUT); no wrap before timeout is declared.

Reset
REQ-027 Reset=0 SHALL immediately force state IDLE, Grant=0, Ack=0, TxStart=0, TxData=0, ErrTimeout=0, counter=0, Last=N_REQ-1 (so index 0 wins first).
REQ-028 Reset asserted mid-transfer SHALL abandon the frame with no Ack; the first grant after release follows REQ-027 priority.
REQ-029 Reset deassertion is synchronized internally; first possible grant is on the second rising edge after release.

Verification
REQ-030 Single request: Req=0001, DataIN[7:0]=8'hEA, model TxBusy 1 cycle after TxStart, TxDone 10 cycles later -> Grant=0001, TxData=8'hEA, one TxStart pulse, one Ack=0001 pulse, Grant=0000 after.
REQ-031 Fairness: Req=1111 held constant, payloads 8'h11/22/33/44 -> grant order 0,1,2,3,0; TxData matches each owner.
REQ-032 Timeout: TxBusy and TxDone tied 0, TIMEOUT=16 -> ErrTimeout=1 exactly 16 cycles after TxStart, Grant cleared, no Ack; next requester served normally.
REQ-033 Request drop: Req=0100 deasserted one cycle after grant, DataIN changed to 8'h00 -> TxData stays original 8'h5A, Ack=0100 still pulses.
REQ-034 Reset mid-frame: Reset=0 during WAIT_DONE with Req=0010 -> all outputs 0 asynchronously; after release with Req=0011, Grant=0001 first.
REQ-035 Missed busy: TxDone pulsed in WAIT_BUSY without TxBusy -> Ack pulses, ErrTimeout stays 0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester/arbiter/transmitter handshake bundle
// Ports: req/data_in (requests, packed payloads), grant/ack (owner, completion pulse),
//        tx_start/tx_data/tx_busy/tx_done (UART transmitter side), err_timeout (sticky error)
interface uart_tx_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] data_in;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        ack;
    logic                    tx_start;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_busy;
    logic                    tx_done;
    logic                    err_timeout;
    modport master (
        output req, data_in, tx_busy, tx_done,
        input  grant, ack, tx_start, tx_data, err_timeout
    );
    modport slave (
        input  req, data_in, tx_busy, tx_done,
        output grant, ack, tx_start, tx_data, err_timeout
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among N_REQ requesters
// Ports: clk; rst_n (async active-low, release synchronised); bus (slave modport):
//        req/data_in/tx_busy/tx_done in, grant/ack/tx_start/tx_data/err_timeout out
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  grant_q, grant_d, ack_q, ack_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [IW-1:0]     last_q, last_d, idx_q, idx_d, win_idx;
    logic              err_q, err_d, run_q, win_vld, done;
    logic [DATA_W-1:0] slice [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign slice[g] = bus.data_in[g*DATA_W +: DATA_W];
    end

    assign cnt_inc = cnt_q + CW'(1);

    // scan from furthest to nearest so the first requester after last_q wins
    always_comb begin
        win_vld = 1'b0;
        win_idx = last_q;
        for (int i = N_REQ; i >= 1; i--) begin
            if (bus.req[IW'((int'(last_q) + i) % N_REQ)]) begin
                win_vld = 1'b1;
                win_idx = IW'((int'(last_q) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ack_d     = '0;
        tx_data_d = tx_data_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        idx_d     = idx_q;
        err_d     = err_q;
        // a done pulse in WAIT_BUSY completes the frame even if busy was never seen
        done      = (state_q == WAIT_BUSY || state_q == WAIT_DONE) && bus.tx_done;
        case (state_q)
            IDLE: if (run_q && win_vld) begin
                state_d          = START;
                grant_d          = '0;
                grant_d[win_idx] = 1'b1;
                idx_d            = win_idx;
                tx_data_d        = slice[win_idx];
            end
            START: begin
                state_d = WAIT_BUSY;
                cnt_d   = '0;
            end
            WAIT_BUSY: if (!bus.tx_done) begin
                if (bus.tx_busy) state_d = WAIT_DONE;
                else if (cnt_inc == CNT_LAST) begin
                    state_d = IDLE;
                    grant_d = '0;
                    last_d  = idx_q;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else cnt_d = cnt_inc;
            end
            default: ;
        endcase
        if (done) begin
            state_d = IDLE;
            grant_d = '0;
            ack_d   = grant_q;
            last_d  = idx_q;
        end
    end

    // run_q holds off arbitration for one edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ack_q     <= '0;
            tx_data_q <= '0;
            cnt_q     <= '0;
            last_q    <= IDX_LAST;
            idx_q     <= '0;
            err_q     <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ack_q     <= ack_d;
            tx_data_q <= tx_data_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            run_q     <= 1'b1;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.ack         = ack_q;
    assign bus.tx_start    = (state_q == START);
    assign bus.tx_data     = tx_data_q;
    assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;

    uart_tx_arbiter_if #(.N_REQ(4), .DATA_W(8)) bus ();

    uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .TIMEOUT(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_grant"}, 32'(bus.grant), 0);
        check({tag, "_ack"}, 32'(bus.ack), 0);
        check({tag, "_start"}, 32'(bus.tx_start), 0);
        check({tag, "_data"}, 32'(bus.tx_data), 0);
        check({tag, "_err"}, 32'(bus.err_timeout), 0);
    endtask

    // entry: just after the granting edge; exit: one edge after the ack edge
    task automatic run_frame(input logic [31:0] g, input logic [31:0] d, input int nb, input string tag);
        check({tag, "_grant"}, 32'(bus.grant), g);
        check({tag, "_data"}, 32'(bus.tx_data), d);
        check({tag, "_start"}, 32'(bus.tx_start), 1);
        check({tag, "_ack0"}, 32'(bus.ack), 0);
        tick();
        check({tag, "_start_off"}, 32'(bus.tx_start), 0);
        bus.tx_busy = 1'b1;
        repeat (nb) tick();
        check({tag, "_hold_grant"}, 32'(bus.grant), g);
        check({tag, "_hold_data"}, 32'(bus.tx_data), d);
        check({tag, "_hold_ack"}, 32'(bus.ack), 0);
        bus.tx_done = 1'b1;
        bus.tx_busy = 1'b0;
        tick();
        bus.tx_done = 1'b0;
        check({tag, "_ack"}, 32'(bus.ack), g);
        check({tag, "_grant_clr"}, 32'(bus.grant), 0);
        check({tag, "_start_ack"}, 32'(bus.tx_start), 0);
        tick();
        check({tag, "_ack_pulse"}, 32'(bus.ack), 0);
    endtask

    initial begin
        bus.req     = '0;
        bus.data_in = '0;
        bus.tx_busy = 1'b0;
        bus.tx_done = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) tick();
        check_zero("reset");
        rst_n = 1'b1;
        bus.req     = 4'b0001;
        bus.data_in = 32'h0000_00EA;
        tick();
        check("sync_gap", 32'(bus.grant), 0);
        tick();
        bus.req = '0;
        run_frame(1, 'hEA, 10, "single");

        bus.req     = 4'b0100;
        bus.data_in = 32'h005A_0000;
        tick();
        bus.req     = '0;
        bus.data_in = '0;
        run_frame(4, 'h5A, 3, "drop");

        bus.req     = 4'b0010;
        bus.data_in = 32'h0000_7700;
        tick();
        bus.req = '0;
        check("miss_grant", 32'(bus.grant), 2);
        check("miss_data", 32'(bus.tx_data), 'h77);
        check("miss_start", 32'(bus.tx_start), 1);
        bus.tx_done = 1'b1;
        tick();
        check("done_in_start", 32'(bus.ack), 0);
        check("done_in_start_grant", 32'(bus.grant), 2);
        tick();
        check("miss_ack", 32'(bus.ack), 2);
        check("miss_grant_clr", 32'(bus.grant), 0);
        check("miss_err", 32'(bus.err_timeout), 0);
        tick();
        check("done_in_idle_ack", 32'(bus.ack), 0);
        check("done_in_idle_grant", 32'(bus.grant), 0);
        bus.tx_done = 1'b0;

        bus.req     = 4'b1001;
        bus.data_in = 32'h9900_00C3;
        tick();
        check("to_grant", 32'(bus.grant), 8);
        check("to_data", 32'(bus.tx_data), 'h99);
        check("to_start", 32'(bus.tx_start), 1);
        repeat (15) tick();
        check("to_err_early", 32'(bus.err_timeout), 0);
        check("to_grant_held", 32'(bus.grant), 8);
        tick();
        check("to_err", 32'(bus.err_timeout), 1);
        check("to_grant_clr", 32'(bus.grant), 0);
        check("to_noack", 32'(bus.ack), 0);
        tick();
        check("to_noack2", 32'(bus.ack), 0);
        bus.req = '0;
        run_frame(1, 'hC3, 2, "after_to");
        check("err_sticky", 32'(bus.err_timeout), 1);

        bus.req     = 4'b0010;
        bus.data_in = 32'h0000_3C00;
        tick();
        check("mid_grant", 32'(bus.grant), 2);
        tick();
        bus.tx_busy = 1'b1;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        bus.tx_busy = 1'b0;
        bus.req     = 4'b0011;
        bus.data_in = 32'h0000_B2A1;
        tick();
        check("rst_held_ack", 32'(bus.ack), 0);
        rst_n = 1'b1;
        tick();
        check("rst_gap", 32'(bus.grant), 0);
        tick();
        run_frame(1, 'hA1, 2, "post_rst");
        bus.req = '0;
        run_frame(2, 'hB2, 2, "post_rst2");

        rst_n = 1'b0;
        bus.req     = 4'b1111;
        bus.data_in = 32'h4433_2211;
        tick();
        rst_n = 1'b1;
        tick();
        check("rr_gap", 32'(bus.grant), 0);
        tick();
        run_frame(1, 'h11, 2, "rr0");
        run_frame(2, 'h22, 2, "rr1");
        run_frame(4, 'h33, 2, "rr2");
        run_frame(8, 'h44, 2, "rr3");
        bus.req = '0;
        run_frame(1, 'h11, 2, "rr4");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
